// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared fetch-stage types and constants
// Contents: FS_TO_DS_BUS_WD (fetch-to-decode bus width), RESET_PC_DEFAULT (first fetch address),
//           fs_state_t (fetch FSM states).
package mycpu_pkg;
    localparam int          FS_TO_DS_BUS_WD  = 64;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fs_state_t;
endpackage

// File: rtl/fs_perf_counter.sv
// fs_perf_counter: 32-bit event counter that saturates at all-ones
// Ports: clk; reset (async, active-low, clears count); inc (count this cycle); cnt (current count).
module fs_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] cnt
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 32'd1;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage; owns the PC, drives the inst SRAM req/addr_ok/data_ok handshake
// Ports: clk; reset (async, active-low); ds_allowin, block_if, br_stall, br_taken, br_target from
//        decode and hazard unit; inst_sram_req/addr out, inst_sram_addr_ok/data_ok/rdata in;
//        fs_to_ds_valid and fs_to_ds_bus {pc, inst} to decode.
// Option: define FS_PERF_CNT_EN to add saturating perf_stall_cnt and perf_cancel_cnt outputs.
module fetch_stage
    import mycpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic                       block_if,
    input  logic                       br_stall,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    output logic                       inst_sram_req,
    output logic [31:0]                inst_sram_addr,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
`ifdef FS_PERF_CNT_EN
    ,
    output logic [31:0]                perf_stall_cnt,
    output logic [31:0]                perf_cancel_cnt
`endif
);
    fs_state_t                  state, state_n;
    logic [31:0]                fetch_pc, pc_n, pend_target, pend_n;
    logic                       cancel, cancel_n, redirect, redirect_n;
    logic                       stall_wait, stall_n, valid, valid_n;
    logic [FS_TO_DS_BUS_WD-1:0] bus, bus_n;
    logic                       br_take, xfer;

    // a branch arriving together with br_stall is not yet trustworthy
    assign br_take        = br_taken && !br_stall;
    assign xfer           = valid && ds_allowin && !block_if;
    // stall_wait parks the FSM in REQ without issuing until the branch resolves
    assign inst_sram_req  = state == REQ && !stall_wait;
    assign inst_sram_addr = fetch_pc;
    assign fs_to_ds_valid = valid;
    assign fs_to_ds_bus   = bus;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            pend_target <= '0;
            cancel      <= 1'b0;
            redirect    <= 1'b0;
            stall_wait  <= 1'b0;
            valid       <= 1'b0;
            bus         <= '0;
        end else begin
            state       <= state_n;
            fetch_pc    <= pc_n;
            pend_target <= pend_n;
            cancel      <= cancel_n;
            redirect    <= redirect_n;
            stall_wait  <= stall_n;
            valid       <= valid_n;
            bus         <= bus_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = fetch_pc;
        pend_n     = pend_target;
        cancel_n   = cancel;
        redirect_n = redirect;
        stall_n    = stall_wait;
        valid_n    = valid;
        bus_n      = bus;
        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                if (stall_wait) begin
                    // nothing is outstanding yet, so a branch retargets the PC directly
                    stall_n = br_stall;
                    pc_n    = br_take ? br_target : fetch_pc;
                end else begin
                    // address must stay stable until accepted; the branch is remembered instead
                    pend_n = br_take ? br_target : pend_target;
                    if (inst_sram_addr_ok) begin
                        state_n    = WAIT;
                        cancel_n   = redirect || br_take;
                        redirect_n = 1'b0;
                    end else begin
                        redirect_n = redirect || br_take;
                    end
                end
            end
            WAIT: begin
                pend_n   = br_take ? br_target : pend_target;
                cancel_n = cancel || br_take;
                if (inst_sram_data_ok) begin
                    cancel_n = 1'b0;
                    if (cancel || br_take) begin
                        state_n = REQ;
                        pc_n    = br_take ? br_target : pend_target;
                    end else begin
                        state_n = HOLD;
                        valid_n = 1'b1;
                        bus_n   = {fetch_pc, inst_sram_rdata};
                    end
                end
            end
            HOLD: begin
                if (br_take) begin
                    state_n = REQ;
                    valid_n = 1'b0;
                    pc_n    = br_target;
                end else if (xfer) begin
                    state_n = REQ;
                    valid_n = 1'b0;
                    pc_n    = fetch_pc + 32'd4;
                    stall_n = br_stall;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef FS_PERF_CNT_EN
    logic drop;
    assign drop = (state == WAIT && inst_sram_data_ok && (cancel || br_take)) || (state == HOLD && br_take);

    fs_perf_counter u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (valid && (block_if || !ds_allowin)),
        .cnt   (perf_stall_cnt)
    );

    fs_perf_counter u_cancel_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop),
        .cnt   (perf_cancel_cnt)
    );
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with an SRAM responder and packet scoreboard
module tb_fetch_stage;
    logic        clk = 1'b0, reset = 1'b1;
    logic        ds_allowin = 1'b1, block_if = 1'b0, br_stall = 1'b0, br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
`ifdef FS_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_cancel_cnt;
`endif

    int          n_pass = 0, n_total = 0, xfer_cnt = 0, stall_model = 0;
    int          addr_delay = 0, data_delay = 0, aw = 0, dw = 0;
    logic [31:0] exp_q[$], acc_q[$];
    logic [31:0] mon_pc;

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .block_if          (block_if),
        .br_stall          (br_stall),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus)
`ifdef FS_PERF_CNT_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_cancel_cnt   (perf_cancel_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic timeout(input string tag);
        n_total++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic wait_xfers(input int n);
        int i = 0;
        while (xfer_cnt < n && i < 200) begin
            @(posedge clk); #1;
            i++;
        end
        if (xfer_cnt < n) timeout("wait_xfers");
    endtask

    task automatic wait_valid();
        int i = 0;
        do begin
            @(posedge clk); #1;
            i++;
        end while (!fs_to_ds_valid && i < 200);
        if (!fs_to_ds_valid) timeout("wait_valid");
    endtask

    task automatic wait_req();
        int i = 0;
        do begin
            @(posedge clk); #1;
            i++;
        end while (!inst_sram_req && i < 200);
        if (!inst_sram_req) timeout("wait_req");
    endtask

    // SRAM model: addr_ok after addr_delay cycles of req, data_ok data_delay cycles after acceptance
    initial forever begin
        @(posedge clk); #1;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        if (!reset) begin
            acc_q.delete();
            aw = 0;
            dw = 0;
        end else begin
            if (acc_q.size() > 0) begin
                if (dw >= data_delay) begin
                    inst_sram_data_ok = 1'b1;
                    inst_sram_rdata   = inst_of(acc_q.pop_front());
                    dw = 0;
                end else dw++;
            end
            if (inst_sram_req) begin
                if (aw >= addr_delay) begin
                    inst_sram_addr_ok = 1'b1;
                    acc_q.push_back(inst_sram_addr);
                    aw = 0;
                end else aw++;
            end
        end
    end

    // packet monitor: every transfer to decode must match the head of the expected queue
    initial forever begin
        @(negedge clk);
        if (reset && fs_to_ds_valid && (block_if || !ds_allowin)) stall_model++;
        if (reset && fs_to_ds_valid && ds_allowin && !block_if && !(br_taken && !br_stall)) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $error("FAIL xfer_unexpected: observed pc %h expected none", fs_to_ds_bus[63:32]);
            end else begin
                mon_pc = exp_q.pop_front();
                chk("xfer_bus", fs_to_ds_bus, {mon_pc, inst_of(mon_pc)});
            end
            xfer_cnt++;
        end
    end

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req", inst_sram_req, 0);
        chk("rst_addr", inst_sram_addr, 32'h1c00_0000);
        chk("rst_valid", fs_to_ds_valid, 0);
        chk("rst_bus", fs_to_ds_bus, 0);
        exp_q.push_back(32'h1c00_0000);
        exp_q.push_back(32'h1c00_0004);
        exp_q.push_back(32'h1c00_0008);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("idle_req", inst_sram_req, 0);
        @(negedge clk);
        chk("first_req", inst_sram_req, 1);
        chk("first_addr", inst_sram_addr, 32'h1c00_0000);
        @(negedge clk);
        chk("wait_req", inst_sram_req, 0);
        chk("wait_valid", fs_to_ds_valid, 0);
        @(negedge clk);
        chk("latency_valid", fs_to_ds_valid, 1);
        wait_xfers(3);

        // block_if holds the packet for three cycles
        exp_q.push_back(32'h1c00_000c);
        wait_valid();
        block_if = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("blk_valid", fs_to_ds_valid, 1);
            chk("blk_bus", fs_to_ds_bus, {32'h1c00_000c, inst_of(32'h1c00_000c)});
            chk("blk_req", inst_sram_req, 0);
            @(posedge clk); #1;
        end
        block_if   = 1'b0;
        data_delay = 2;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_xfer_valid", fs_to_ds_valid, 0);
        chk("post_xfer_req", inst_sram_req, 1);
        chk("post_xfer_addr", inst_sram_addr, 32'h1c00_0010);

        // taken branch while waiting for data
        @(posedge clk); #1;
        br_taken  = 1'b1;
        br_target = 32'h1c00_0100;
        exp_q.push_back(32'h1c00_0100);
        @(posedge clk); #1;
        br_taken = 1'b0;
        wait_req();
        @(negedge clk);
        chk("wait_br_addr", inst_sram_addr, 32'h1c00_0100);
`ifdef FS_PERF_CNT_EN
        chk("perf_cancel_1", perf_cancel_cnt, 1);
`endif
        data_delay = 0;
        addr_delay = 2;

        // taken branch during REQ while addr_ok is held off
        wait_xfers(5);
        br_taken  = 1'b1;
        br_target = 32'h1c00_0200;
        exp_q.push_back(32'h1c00_0200);
        @(negedge clk);
        chk("req_br_req0", inst_sram_req, 1);
        chk("req_br_addr0", inst_sram_addr, 32'h1c00_0104);
        @(posedge clk); #1;
        br_taken = 1'b0;
        @(negedge clk);
        chk("req_br_addr1", inst_sram_addr, 32'h1c00_0104);
        @(negedge clk);
        chk("req_br_req2", inst_sram_req, 1);
        chk("req_br_addr2", inst_sram_addr, 32'h1c00_0104);
        wait_req();
        @(negedge clk);
        chk("req_br_target", inst_sram_addr, 32'h1c00_0200);
`ifdef FS_PERF_CNT_EN
        chk("perf_cancel_2", perf_cancel_cnt, 2);
`endif
        addr_delay = 0;
        wait_xfers(6);

        // br_stall for four cycles starting with the transfer
        exp_q.push_back(32'h1c00_0204);
        wait_valid();
        br_stall = 1'b1;
        @(negedge clk);
        chk("stall_req0", inst_sram_req, 0);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("stall_req", inst_sram_req, 0);
        end
        @(posedge clk); #1;
        br_stall = 1'b0;
        @(negedge clk);
        chk("stall_drop_req", inst_sram_req, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_resume_req", inst_sram_req, 1);
        chk("stall_resume_addr", inst_sram_addr, 32'h1c00_0208);

        // branch with br_stall in HOLD is ignored
        exp_q.push_back(32'h1c00_0208);
        wait_valid();
        block_if  = 1'b1;
        br_stall  = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h1c00_0300;
        @(negedge clk);
        chk("ign_valid0", fs_to_ds_valid, 1);
        @(posedge clk); #1;
        br_taken = 1'b0;
        br_stall = 1'b0;
        @(negedge clk);
        chk("ign_valid1", fs_to_ds_valid, 1);
        chk("ign_bus", fs_to_ds_bus, {32'h1c00_0208, inst_of(32'h1c00_0208)});
        @(posedge clk); #1;
        block_if = 1'b0;
        wait_xfers(8);
        @(negedge clk);
        chk("ign_next_addr", inst_sram_addr, 32'h1c00_020c);

        // taken branch in HOLD drops the packet
        wait_valid();
        br_taken  = 1'b1;
        br_target = 32'h1c00_0400;
        exp_q.push_back(32'h1c00_0400);
        @(posedge clk); #1;
        br_taken = 1'b0;
        @(negedge clk);
        chk("drop_valid", fs_to_ds_valid, 0);
        chk("drop_req", inst_sram_req, 1);
        chk("drop_addr", inst_sram_addr, 32'h1c00_0400);
        wait_xfers(9);

        // PC wraps from the top of the address space
        wait_valid();
        br_taken  = 1'b1;
        br_target = 32'hffff_fffc;
        exp_q.push_back(32'hffff_fffc);
        exp_q.push_back(32'h0000_0000);
        @(posedge clk); #1;
        br_taken = 1'b0;
        @(negedge clk);
        chk("top_addr", inst_sram_addr, 32'hffff_fffc);
        wait_xfers(10);
        @(negedge clk);
        chk("wrap_addr", inst_sram_addr, 32'h0000_0000);
        wait_xfers(11);
        ds_allowin = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("queue_empty", exp_q.size(), 0);
        chk("held_valid", fs_to_ds_valid, 1);
`ifdef FS_PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, stall_model);
        chk("perf_cancel_4", perf_cancel_cnt, 4);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
